targ_uart_tx_sched: RTL and testbench



---
 rtl/targ_uart_tx_sched.sv | 183 ++++++++++++++++++
 tb/tb_targ_uart_tx_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/targ_uart_tx_sched.sv
// targ_uart_tx_sched: round-robin scheduler sharing one target-UART byte
// transmitter between N requesters. Issues one start pulse per byte, follows
// tx_busy through the character, times out if busy never rises, and applies
// baud-increment updates only between characters.
// Optional inter-byte gap state: define TARG_UART_TX_SCHED_GAP_EN.
module targ_uart_tx_sched #(
  parameter int          N                = 4,
  parameter logic [15:0] DEFAULT_BAUD_INC = 16'd1208,
  parameter int          BUSY_TIMEOUT     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_lock,
  output logic [N-1:0]     ack,
  output logic [2:0]       grant_id,
  input  logic [15:0]      baud_inc_cfg,
  input  logic             baud_inc_wr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [15:0]      tx_baud_inc,
  output logic             idle,
  output logic             tx_err,
  input  logic [15:0]      gap_cycles
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
`ifdef TARG_UART_TX_SCHED_GAP_EN
  localparam logic [1:0] S_GAP       = 2'd3;
`endif

  logic [1:0]    rst_sync;
  logic          rst_n_int;
  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_owner;
  logic          lock_valid;
  logic [15:0]   cnt;
  logic [15:0]   baud_pend;
  logic          baud_pend_vld;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_next;
  logic [IW:0]   cand_sum;
  logic          grant_go;
  logic          baud_copy;

`ifndef TARG_UART_TX_SCHED_GAP_EN
  logic          unused_gap;
  assign unused_gap = ^gap_cycles;
`endif

  // Reset assertion is immediate; release is synchronised to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // Winner selection: a live lock owner first, otherwise the first request at
  // or above the rr pointer; scanning offsets downward leaves the nearest one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    if (lock_valid && req[lock_owner]) begin
      win_found = 1'b1;
      win_idx   = lock_owner;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        cand_sum = {1'b0, rr_ptr} + (IW+1)'(i);
        if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
        if (req[cand_sum[IW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = cand_sum[IW-1:0];
        end
      end
    end
  end

  assign win_next  = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
  assign grant_go  = (state == S_IDLE) && !tx_busy && win_found;
  assign baud_copy = (state == S_IDLE) && !tx_busy && baud_pend_vld;
  assign idle      = (state == S_IDLE) && !tx_busy && !(|req) && !baud_pend_vld;

  // Scheduler FSM: grant in IDLE, then follow tx_busy through the character.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= S_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      ack        <= '0;
      tx_err     <= 1'b0;
      grant_id   <= 3'd0;
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_valid <= 1'b0;
      cnt        <= 16'd0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      tx_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_go) begin
            tx_start     <= 1'b1;
            tx_data      <= req_data[8*win_idx +: 8];
            ack[win_idx] <= 1'b1;
            grant_id     <= 3'(win_idx);
            cnt          <= 16'd0;
            state        <= S_WAIT_BUSY;
            if (req_lock[win_idx]) begin
              lock_valid <= 1'b1;
              lock_owner <= win_idx;
            end else begin
              lock_valid <= 1'b0;
              rr_ptr     <= win_next;
            end
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == 16'(BUSY_TIMEOUT - 1)) begin
            tx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef TARG_UART_TX_SCHED_GAP_EN
            if (gap_cycles != 16'd0) begin
              cnt   <= gap_cycles;
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef TARG_UART_TX_SCHED_GAP_EN
        S_GAP: begin
          if (!tx_busy) begin
            if (cnt <= 16'd1) state <= S_IDLE;
            else              cnt   <= cnt - 16'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Baud configuration: writes land in a pending register at any time and are
  // copied to the transmitter only between characters.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      tx_baud_inc   <= DEFAULT_BAUD_INC;
      baud_pend     <= DEFAULT_BAUD_INC;
      baud_pend_vld <= 1'b0;
    end else begin
      if (baud_copy) tx_baud_inc <= baud_pend;
      if (baud_inc_wr) begin
        baud_pend     <= baud_inc_cfg;
        baud_pend_vld <= 1'b1;
      end else if (baud_copy) begin
        baud_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_targ_uart_tx_sched.sv
// tb_targ_uart_tx_sched: directed and randomized checks of the UART transmit
// scheduler against an arbitration model kept in the bench.
// Build with TARG_UART_TX_SCHED_GAP_EN defined to exercise the gap state.
module tb_targ_uart_tx_sched;

  localparam int          N        = 4;
  localparam logic [15:0] DEF_BAUD = 16'd1208;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_lock = '0;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic [15:0] baud_inc_cfg = '0;
  logic        baud_inc_wr = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [15:0] tx_baud_inc;
  logic        idle;
  logic        tx_err;
  logic [15:0] gap_cycles = '0;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] dat [4];
  int         m_rr;
  int         m_lock;
  bit         m_lock_valid;
  int         w;
  int         n;
  bit         started;
  int         exp_order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] lk_seq [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  int         lock_exp [5] = '{2, 2, 2, 3, 0};
  logic [3:0] rnd_req;
  logic [3:0] rnd_lock;

  targ_uart_tx_sched #(.N(N), .DEFAULT_BAUD_INC(DEF_BAUD), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_lock(req_lock), .ack(ack), .grant_id(grant_id),
    .baud_inc_cfg(baud_inc_cfg), .baud_inc_wr(baud_inc_wr),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_baud_inc(tx_baud_inc), .idle(idle), .tx_err(tx_err),
    .gap_cycles(gap_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic packData();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  endtask

  // Reference arbitration: live lock owner first, else nearest request from rr.
  function automatic int modelWinner(input logic [3:0] r);
    if (m_lock_valid && r[m_lock]) return m_lock;
    for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    return 0;
  endfunction

  task automatic doReset();
    reset_n = 1'b0; req = '0; req_lock = '0; tx_busy = 1'b0;
    baud_inc_wr = 1'b0; baud_inc_cfg = '0; gap_cycles = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    m_rr = 0; m_lock = 0; m_lock_valid = 1'b0;
  endtask

  // Present requests in IDLE and check the registered grant one cycle later.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] lk, output int win);
    req = r; req_lock = lk; packData();
    win = modelWinner(r);
    @(negedge clk);
    checkOutput("tx_start_on_grant", 32'(tx_start), 32'd1);
    checkOutput("ack_onehot", 32'(ack), 32'(4'b0001 << win));
    checkOutput("grant_id", 32'(grant_id), 32'(win));
    checkOutput("tx_data", 32'(tx_data), 32'(dat[win]));
    checkOutput("tx_err_quiet", 32'(tx_err), 32'd0);
    if (lk[win]) begin
      m_lock_valid = 1'b1; m_lock = win;
    end else begin
      m_lock_valid = 1'b0; m_rr = (win + 1) % N;
    end
    dat[win] = dat[win] ^ 8'(1 + $urandom_range(254));
    packData();
  endtask

  // Emulate the transmitter being busy for 'hold' cycles, then finishing.
  task automatic busyPhase(input int hold);
    tx_busy = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      checkOutput("no_restart_busy", 32'(tx_start), 32'd0);
      checkOutput("ack_quiet_busy", 32'(ack), 32'd0);
      checkOutput("idle_low_busy", 32'(idle), 32'd0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("no_start_on_done", 32'(tx_start), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    doReset();

    // Reset state
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_tx_err", 32'(tx_err), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_baud", 32'(tx_baud_inc), 32'(DEF_BAUD));
    checkOutput("rst_idle", 32'(idle), 32'd1);

    // Single requester
    dat[0] = 8'h5A;
    applyStimulus(4'b0001, 4'b0000, w);
    checkOutput("single_data_5a", 32'(tx_data), 32'h5A);
    req = '0;
    busyPhase(3);
    checkOutput("idle_after_single", 32'(idle), 32'd1);

    // Continuous round robin from a fresh reset
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b0000, w);
      checkOutput("rr_order", 32'(w), 32'(exp_order[k]));
      busyPhase(1 + $urandom_range(2));
    end

    // Lock by requester 2
    applyStimulus(4'b1111, 4'b0000, w);
    busyPhase(1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, lk_seq[k], w);
      checkOutput("lock_order", 32'(w), 32'(lock_exp[k]));
      busyPhase(1);
    end

    // Lock owner drops its request
    applyStimulus(4'b1111, 4'b0010, w);
    busyPhase(1);
    applyStimulus(4'b1101, 4'b0000, w);
    busyPhase(1);

    // Randomized request and lock patterns
    repeat (20) begin
      rnd_req  = 4'($urandom_range(1, 15));
      rnd_lock = 4'($urandom);
      applyStimulus(rnd_req, rnd_lock, w);
      busyPhase(1 + $urandom_range(3));
    end
    req = '0; req_lock = '0;

    // Baud write during a character
    applyStimulus(4'b0001, 4'b0000, w);
    req = '0;
    tx_busy = 1'b1;
    @(negedge clk);
    baud_inc_cfg = 16'h0971; baud_inc_wr = 1'b1;
    @(negedge clk);
    baud_inc_wr = 1'b0;
    checkOutput("baud_held_busy", 32'(tx_baud_inc), 32'(DEF_BAUD));
    @(negedge clk);
    checkOutput("baud_held_busy2", 32'(tx_baud_inc), 32'(DEF_BAUD));
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("baud_held_wait_done", 32'(tx_baud_inc), 32'(DEF_BAUD));
    @(negedge clk);
    checkOutput("baud_applied_idle", 32'(tx_baud_inc), 32'h0971);

    // Busy never rises
    applyStimulus(4'b0001, 4'b0000, w);
    req = '0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("tx_err_early", 32'(tx_err), 32'd0);
    end
    @(negedge clk);
    checkOutput("tx_err_timeout", 32'(tx_err), 32'd1);
    applyStimulus(4'b0010, 4'b0000, w);
    req = '0;
    busyPhase(2);

    // Reset in the middle of a character
    applyStimulus(4'b0100, 4'b0000, w);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    checkOutput("midrst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("midrst_baud", 32'(tx_baud_inc), 32'(DEF_BAUD));
    m_rr = 0; m_lock = 0; m_lock_valid = 1'b0;
    req = 4'b0001; req_lock = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("no_start_while_busy", 32'(tx_start), 32'd0);
    end
    tx_busy = 1'b0;
    applyStimulus(4'b0001, 4'b0000, w);
    req = '0;
    busyPhase(1);

    // Inter-byte gap (ignored unless the gap feature is built in)
    gap_cycles = 16'd10;
    applyStimulus(4'b0001, 4'b0000, w);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    n = 0; started = 1'b0;
    while (n < 40 && !started) begin
      @(negedge clk);
      n++;
      if (tx_start) started = 1'b1;
    end
`ifdef TARG_UART_TX_SCHED_GAP_EN
    checkOutput("gap_latency", 32'(n), 32'd12);
`else
    checkOutput("gap_latency", 32'(n), 32'd2);
`endif
    checkOutput("gap_data", 32'(tx_data), 32'(dat[0]));
    req = '0;
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
`ifdef TARG_UART_TX_SCHED_GAP_EN
    checkOutput("idle_in_gap", 32'(idle), 32'd0);
`else
    checkOutput("idle_in_gap", 32'(idle), 32'd1);
`endif
    repeat (12) @(negedge clk);
    checkOutput("idle_after_gap", 32'(idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
